// File: rtl/word_link_pkg.sv
// Shared definitions for the 16-bit word link: Hamming(21,16) codeword layout
// and the receive deframer state encoding.
package word_link_pkg;

    localparam int CW_WIDTH   = 21;
    localparam int DATA_WIDTH = 16;
    localparam int NUM_PARITY = 5;
    localparam logic [7:0] SYNC_MASK = 8'hE0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_B2 = 2'd1,
        WAIT_B3 = 2'd2
    } deframer_state_t;

    // Codeword position (1-based) of the k-th parity bit: 1, 2, 4, 8, 16.
    function automatic int parity_pos(input int k);
        return 1 << k;
    endfunction

    function automatic bit is_parity_pos(input int p);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_PARITY; k++) begin
            if (parity_pos(k) == p) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Codeword position (1-based) holding data bit i; data fills non-parity slots in ascending order.
    function automatic int data_pos(input int i);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        for (int p = 1; p <= CW_WIDTH; p++) begin
            if (!is_parity_pos(p)) begin
                if (n == i) begin
                    pos = p;
                end
                n++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming21_dec.sv
// Registered single-error-correcting Hamming(21,16) decoder, one cycle of latency.
// Outputs hold their last decoded value until the next valid input.
module hamming21_dec
    import word_link_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [CW_WIDTH-1:0]   cw_i,
    input  logic                  valid_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  corrected_o,
    output logic                  uncorrectable_o
);

    logic [4:0]            syndrome;
    logic                  in_range;
    logic [CW_WIDTH-1:0]   flip_mask;
    logic [CW_WIDTH-1:0]   cw_fixed;
    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  corrected_q;
    logic                  uncorrectable_q;

    always_comb begin
        syndrome = '0;
        for (int p = 1; p <= CW_WIDTH; p++) begin
            if (cw_i[p-1]) begin
                syndrome = syndrome ^ 5'(p);
            end
        end
    end

    // Out-of-range syndromes leave the mask empty, so the raw data bits pass through.
    assign in_range  = (syndrome != 5'd0) && (syndrome <= 5'(CW_WIDTH));
    assign flip_mask = in_range ? (CW_WIDTH'(1) << (syndrome - 5'd1)) : '0;
    assign cw_fixed  = cw_i ^ flip_mask;

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_extract
            assign data_d[gi] = cw_fixed[data_pos(gi) - 1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            data_q          <= '0;
            valid_q         <= 1'b0;
            corrected_q     <= 1'b0;
            uncorrectable_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q          <= data_d;
                corrected_q     <= in_range;
                uncorrectable_q <= (syndrome > 5'(CW_WIDTH));
            end
        end
    end

    assign data_o          = data_q;
    assign valid_o         = valid_q;
    assign corrected_o     = corrected_q;
    assign uncorrectable_o = uncorrectable_q;

endmodule

// File: rtl/word_deframer.sv
// Receive-side deframer: realigns the UART byte stream into 21-bit codewords
// using a sync-bit check and inter-byte timeout, then SEC-decodes each word.
module word_deframer
    import word_link_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 434,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_byte_valid,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  err_corrected,
    output logic                  err_uncorrectable,
    output logic                  frame_err,
    output logic [7:0]            err_count
);

    localparam int TIMEOUT_CLKS = CLKS_PER_BIT * 10 * TIMEOUT_BYTES;
    localparam int TMO_W        = $clog2(TIMEOUT_CLKS + 1);

    deframer_state_t     state_q, state_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [CW_WIDTH-1:0] cw_q, cw_d;
    logic                cw_valid_q, cw_valid_d;
    logic                frame_err_q, frame_err_d;
    logic [7:0]          err_count_q, err_count_d;

    logic                sync_ok;
    logic                timed_out;
    logic                dec_valid;
    logic                dec_corrected;
    logic                dec_uncorrectable;
    logic [1:0]          err_inc;
    logic [8:0]          err_sum;

    assign sync_ok   = (rx_byte & SYNC_MASK) == 8'h00;
    assign timed_out = (tmo_q == TMO_W'(TIMEOUT_CLKS));

    // An arriving byte is checked before the timeout, so it wins on the boundary cycle.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        cw_d        = cw_q;
        cw_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (rx_byte_valid) begin
                    if (sync_ok) begin
                        cw_d[20:16] = rx_byte[4:0];
                        state_d     = WAIT_B2;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            WAIT_B2: begin
                if (rx_byte_valid) begin
                    cw_d[15:8] = rx_byte;
                    tmo_d      = '0;
                    state_d    = WAIT_B3;
                end else if (timed_out) begin
                    frame_err_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            WAIT_B3: begin
                if (rx_byte_valid) begin
                    cw_d[7:0]  = rx_byte;
                    cw_valid_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = IDLE;
                end else if (timed_out) begin
                    frame_err_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                tmo_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    hamming21_dec u_dec (
        .clk             (clk),
        .rstb            (rstb),
        .cw_i            (cw_q),
        .valid_i         (cw_valid_q),
        .data_o          (data_out),
        .valid_o         (dec_valid),
        .corrected_o     (dec_corrected),
        .uncorrectable_o (dec_uncorrectable)
    );

    // A framing error and a decode flag landing together add two.
    assign err_inc = {1'b0, frame_err_q}
                   + {1'b0, dec_valid & (dec_corrected | dec_uncorrectable)};
    assign err_sum = {1'b0, err_count_q} + {7'd0, err_inc};

    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (err_sum > 9'd255) begin
            err_count_d = 8'hFF;
        end else begin
            err_count_d = err_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            cw_q        <= '0;
            cw_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            cw_q        <= cw_d;
            cw_valid_q  <= cw_valid_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign data_out_valid    = dec_valid;
    assign err_corrected     = dec_corrected;
    assign err_uncorrectable = dec_uncorrectable;
    assign frame_err         = frame_err_q;
    assign err_count         = err_count_q;

endmodule

// File: tb/tb_word_deframer.sv
// Self-checking bench for word_deframer: table-driven frames plus hand-written
// sync, timeout, saturation and reset sequences, checked through a scoreboard.
module tb_word_deframer;

    localparam int TMO = 434 * 10 * 4;

    logic        clk;
    logic        rstb;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic        err_clr;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic        err_corrected;
    logic        err_uncorrectable;
    logic        frame_err;
    logic [7:0]  err_count;

    word_deframer dut (
        .clk               (clk),
        .rstb              (rstb),
        .rx_byte           (rx_byte),
        .rx_byte_valid     (rx_byte_valid),
        .err_clr           (err_clr),
        .data_out          (data_out),
        .data_out_valid    (data_out_valid),
        .err_corrected     (err_corrected),
        .err_uncorrectable (err_uncorrectable),
        .frame_err         (frame_err),
        .err_count         (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests   = 0;
    int fails   = 0;
    int fe_cnt  = 0;
    int fe_last = -1;
    int exp_cnt = 0;

    typedef struct {
        logic [15:0] data;
        logic        corr;
        logic        unc;
        int          due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0]  b1, b2, b3;
        logic [15:0] data;
        logic        corr;
        logic        unc;
    } vec_t;
    vec_t vecs[14];

    // Scoreboard monitor: every strobe must match the oldest expected word on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (frame_err) begin
            fe_cnt  = fe_cnt + 1;
            fe_last = cyc;
        end
        if (data_out_valid) begin
            tests = tests + 1;
            if (sb.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_strobe: got data %h at cycle %0d, required no strobe", data_out, cyc);
            end else begin
                e = sb.pop_front();
                if (cyc != e.due || data_out !== e.data || err_corrected !== e.corr
                    || err_uncorrectable !== e.unc) begin
                    fails = fails + 1;
                    $display("FAIL word: got %h corr %b unc %b at cycle %0d, required %h corr %b unc %b at cycle %0d",
                             data_out, err_corrected, err_uncorrectable, cyc, e.data, e.corr, e.unc, e.due);
                end else begin
                    $display("[TB] word %h corr %b unc %b ok", data_out, err_corrected, err_uncorrectable);
                end
            end
        end else if (sb.size() > 0 && cyc >= sb[0].due) begin
            e = sb.pop_front();
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL missing_strobe: got no strobe at cycle %0d, required %h", cyc, e.data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    function automatic logic [20:0] encode(input logic [15:0] d);
        logic [20:0] cw;
        logic        par;
        int          j;
        cw = '0;
        j  = 0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            par = 1'b0;
            for (int p = 1; p <= 21; p++) begin
                if (((p & (1 << k)) != 0) && ((p & (p - 1)) != 0)) par = par ^ cw[p-1];
            end
            cw[(1 << k) - 1] = par;
        end
        return cw;
    endfunction

    // Called at a negedge; the byte is presented for exactly one cycle.
    task automatic send_byte(input logic [7:0] b);
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        @(negedge clk);
        rx_byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                              input logic [15:0] d, input logic corr, input logic unc, input int gap);
        exp_t e;
        send_byte(b1);
        idle(gap);
        send_byte(b2);
        idle(gap);
        e.data = d;
        e.corr = corr;
        e.unc  = unc;
        e.due  = cyc + 2;
        sb.push_back(e);
        if (corr || unc) exp_cnt = sat_add(exp_cnt, 1);
        send_byte(b3);
    endtask

    initial begin
        logic [20:0] cw;
        logic [15:0] d;
        int          x;
        int          fe0;

        rstb          = 1'b0;
        rx_byte       = 8'h00;
        rx_byte_valid = 1'b0;
        err_clr       = 1'b0;
        idle(3);
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_valid", 32'(data_out_valid), 32'h0);
        check("reset_corr", 32'(err_corrected), 32'h0);
        check("reset_unc", 32'(err_uncorrectable), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_err_count", 32'(err_count), 32'h0);
        rstb = 1'b1;
        idle(2);

        // Test-plan frames; the first uses real 10-bit byte spacing.
        send_frame(8'h1F, 8'hFF, 8'hFE, 16'hFFFF, 1'b0, 1'b0, 4339);
        idle(4);
        check("clean_err_count", 32'(err_count), 32'd0);
        send_frame(8'h00, 8'h00, 8'h04, 16'h0000, 1'b1, 1'b0, 2);
        idle(4);
        check("corr_err_count", 32'(err_count), 32'd1);
        send_frame(8'h10, 8'h00, 8'h04, 16'h8001, 1'b0, 1'b1, 2);
        idle(4);
        check("unc_err_count", 32'(err_count), 32'd2);

        // Table of encoded words, odd entries carry one flipped bit; sent back to back.
        for (int i = 0; i < 12; i++) begin
            d  = 16'($urandom);
            cw = encode(d);
            if (i % 2 == 1) cw[$urandom_range(0, 20)] ^= 1'b1;
            vecs[i].b1   = {3'b000, cw[20:16]};
            vecs[i].b2   = cw[15:8];
            vecs[i].b3   = cw[7:0];
            vecs[i].data = d;
            vecs[i].corr = (i % 2 == 1);
            vecs[i].unc  = 1'b0;
        end
        vecs[12] = '{8'h1F, 8'hFF, 8'hFE, 16'hFFFF, 1'b0, 1'b0};
        vecs[13] = '{8'h10, 8'h00, 8'h04, 16'h8001, 1'b0, 1'b1};
        for (int i = 0; i < 14; i++) begin
            send_frame(vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].data, vecs[i].corr, vecs[i].unc, 0);
        end
        idle(4);
        check("table_err_count", 32'(err_count), 32'(exp_cnt));
        check("table_no_frame_err", 32'(fe_cnt), 32'd0);

        // Sync violation then recovery.
        fe0 = fe_cnt;
        x   = cyc;
        send_byte(8'h20);
        idle(2);
        exp_cnt = sat_add(exp_cnt, 1);
        check("sync_frame_err", 32'(fe_cnt - fe0), 32'd1);
        check("sync_frame_err_cycle", 32'(fe_last), 32'(x + 1));
        send_frame(8'h1F, 8'hFF, 8'hFE, 16'hFFFF, 1'b0, 1'b0, 0);
        idle(4);
        check("sync_err_count", 32'(err_count), 32'(exp_cnt));

        // Timeout after byte2: counter reaches the limit in cycle x+1+TMO, pulse one cycle later.
        fe0 = fe_cnt;
        send_byte(8'h1F);
        x = cyc;
        send_byte(8'hFF);
        idle(TMO + 3);
        exp_cnt = sat_add(exp_cnt, 1);
        check("timeout_frame_err", 32'(fe_cnt - fe0), 32'd1);
        check("timeout_cycle", 32'(fe_last), 32'(x + TMO + 2));
        send_frame(8'h00, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 0);
        idle(4);
        check("timeout_err_count", 32'(err_count), 32'(exp_cnt));

        // Byte3 on exactly the timeout cycle is accepted.
        fe0 = fe_cnt;
        send_byte(8'h1F);
        x = cyc;
        send_byte(8'hFF);
        idle(TMO);
        check("boundary_cycle", 32'(cyc), 32'(x + 1 + TMO));
        send_frame_tail: begin
            exp_t e;
            e.data = 16'hFFFF;
            e.corr = 1'b0;
            e.unc  = 1'b0;
            e.due  = cyc + 2;
            sb.push_back(e);
            send_byte(8'hFE);
        end
        idle(4);
        check("boundary_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
        check("boundary_err_count", 32'(err_count), 32'(exp_cnt));

        // Saturation with 300 sync errors.
        fe0 = fe_cnt;
        repeat (300) send_byte(8'h20);
        idle(4);
        exp_cnt = 255;
        check("sat_frame_errs", 32'(fe_cnt - fe0), 32'd300);
        check("sat_err_count", 32'(err_count), 32'd255);

        // err_clr held across the cycle the new error would be counted.
        err_clr = 1'b1;
        send_byte(8'h20);
        idle(1);
        err_clr = 1'b0;
        idle(3);
        exp_cnt = 0;
        check("clr_priority", 32'(err_count), 32'd0);

        // Reset between byte2 and byte3.
        send_byte(8'h1F);
        send_byte(8'hFF);
        rstb = 1'b0;
        #1;
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_flags", 32'({data_out_valid, err_corrected, err_uncorrectable, frame_err}), 32'h0);
        check("rst_err_count", 32'(err_count), 32'h0);
        idle(3);
        rstb = 1'b1;
        idle(3);

        // Reset while a decode is pending: no strobe may appear.
        send_byte(8'h1F);
        send_byte(8'hFF);
        send_byte(8'hFE);
        rstb = 1'b0;
        idle(3);
        rstb = 1'b1;
        idle(4);
        check("rst_pending_valid", 32'(data_out_valid), 32'h0);

        send_frame(8'h00, 8'h00, 8'h04, 16'h0000, 1'b1, 1'b0, 0);
        idle(4);
        check("post_reset_err_count", 32'(err_count), 32'(exp_cnt));

        idle(10);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
